// File: rtl/mem_cycle_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer sharing one single-port memory.
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
module mem_cycle_sequencer #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] alu_out,
  input  logic [DW-1:0] store_data,
  input  logic          is_load,
  input  logic          is_store,
  input  logic          reg_wr_dec,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] instr,
  output logic [DW-1:0] read_data,
  output logic          pc_we,
  output logic          reg_we,
  output logic [2:0]    state_o,
  output logic          bus_err
);

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    EXEC  = 3'd1,
    MEM   = 3'd2,
    WB    = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] instr_q, rdata_q;
  logic          access, in_mem, expire;
  logic          pc_we_c, reg_we_c;

  assign access = (state == FETCH) || (state == MEM);
  assign in_mem = (state == MEM);

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  logic [7:0] cnt, cnt_n;

  assign expire = access && !mem_ack && (cnt == LIMIT);

  // Counter restarts on every state change and on every ack.
  always_comb begin
    cnt_n = cnt + 8'd1;
    if (!access || mem_ack || (state_n != state))
      cnt_n = 8'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt <= 8'd0;
    else       cnt <= cnt_n;
  end

  assign bus_err = !reset && (state == ERR);
`else
  assign expire  = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    pc_we_c  = 1'b0;
    reg_we_c = 1'b0;
    unique case (state)
      FETCH: begin
        if (expire)       state_n = ERR;
        else if (mem_ack) state_n = EXEC;
      end
      EXEC: begin
        if (is_load || is_store) begin
          state_n = MEM;
        end else begin
          pc_we_c  = 1'b1;
          reg_we_c = reg_wr_dec;
          state_n  = FETCH;
        end
      end
      MEM: begin
        if (expire)       state_n = ERR;
        else if (mem_ack) state_n = WB;
      end
      WB: begin
        pc_we_c  = 1'b1;
        reg_we_c = reg_wr_dec && is_load;
        state_n  = FETCH;
      end
      ERR:     state_n = ERR;
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      instr_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      if ((state == FETCH) && mem_ack)
        instr_q <= mem_rdata;
      if (in_mem && mem_ack && is_load)
        rdata_q <= mem_rdata;
    end
  end

  // Every output is forced low while reset is held.
  assign mem_req   = !reset && access;
  assign mem_we    = !reset && in_mem && is_store && !is_load;
  assign mem_addr  = reset ? '0 : (in_mem ? alu_out : pc);
  assign mem_wdata = (!reset && in_mem) ? store_data : '0;
  assign instr     = reset ? '0 : instr_q;
  assign read_data = reset ? '0 : rdata_q;
  assign pc_we     = !reset && pc_we_c;
  assign reg_we    = !reset && reg_we_c;
  assign state_o   = reset ? 3'd0 : state;

endmodule

// File: tb/tb_mem_cycle_sequencer.sv
// Self-checking bench for mem_cycle_sequencer: directed scenarios plus
// randomized instruction streams against a transaction-level model.
module tb_mem_cycle_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0, alu_out = '0, store_data = '0, mem_rdata = '0;
  logic        is_load = 1'b0, is_store = 1'b0, reg_wr_dec = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, pc_we, reg_we, bus_err;
  logic [31:0] mem_addr, mem_wdata, instr, read_data;
  logic [2:0]  state_o;

  int checks = 0;
  int errors = 0;

  mem_cycle_sequencer #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .pc(pc), .alu_out(alu_out),
    .store_data(store_data), .is_load(is_load), .is_store(is_store),
    .reg_wr_dec(reg_wr_dec), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .instr(instr), .read_data(read_data),
    .pc_we(pc_we), .reg_we(reg_we), .state_o(state_o), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ack;
    logic [31:0] rdata;
    logic        req, we, pcwe, regwe;
    logic [2:0]  st;
    logic [31:0] addr, wdata, ir, rd;
  } cyc_t;

  cyc_t        q[$];
  logic [31:0] m_ir, m_rd;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    mem_ack = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // Expand one instruction into its expected cycle-by-cycle trace.
  function automatic void plan(input logic [31:0] p, a, s, w,
                               input logic ld, st, rw,
                               input int wf, wm);
    cyc_t c;
    logic mem;
    logic [31:0] d;
    mem = ld | st;
    for (int i = 0; i <= wf; i++) begin
      c = '0;
      c.ack = (i == wf);
      c.rdata = c.ack ? w : $urandom;
      c.req = 1'b1;
      c.addr = p;
      c.ir = m_ir;
      c.rd = m_rd;
      q.push_back(c);
    end
    m_ir = w;
    c = '0;
    c.ack = 1'($urandom_range(0, 1));
    c.rdata = $urandom;
    c.st = 3'd1;
    c.pcwe = !mem;
    c.regwe = !mem && rw;
    c.ir = m_ir;
    c.rd = m_rd;
    q.push_back(c);
    if (mem) begin
      d = $urandom;
      for (int i = 0; i <= wm; i++) begin
        c = '0;
        c.ack = (i == wm);
        c.rdata = c.ack ? d : $urandom;
        c.req = 1'b1;
        c.we = st && !ld;
        c.st = 3'd2;
        c.addr = a;
        c.wdata = s;
        c.ir = m_ir;
        c.rd = m_rd;
        q.push_back(c);
      end
      if (ld) m_rd = d;
      c = '0;
      c.ack = 1'($urandom_range(0, 1));
      c.rdata = $urandom;
      c.st = 3'd3;
      c.pcwe = 1'b1;
      c.regwe = rw && ld;
      c.ir = m_ir;
      c.rd = m_rd;
      q.push_back(c);
    end
  endfunction

  task automatic test_reset;
    logic [135:0] z;
    reset = 1'b1;
    pc = 32'h1234;
    alu_out = 32'h5678;
    store_data = 32'hCAFE;
    is_store = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF;
    #1;
    z = {mem_req, mem_we, pc_we, reg_we, bus_err, state_o,
         mem_addr, mem_wdata, instr, read_data};
    checks++;
    if (z !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", z);
    end
    step();
    reset = 1'b0;
    mem_ack = 1'b0;
    is_store = 1'b0;
    #1;
    checks++;
    if ({state_o, mem_req, mem_we, mem_addr, instr, read_data} !==
        {3'd0, 1'b1, 1'b0, 32'h1234, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_release st=%0d req=%b addr=%h ir=%h want 0/1/1234/0",
               state_o, mem_req, mem_addr, instr);
    end
  endtask

  task automatic test_alu;
    do_reset();
    pc = 32'h0;
    is_load = 1'b0;
    is_store = 1'b0;
    reg_wr_dec = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'h0000_0013;
    #1;
    checks++;
    if ({state_o, mem_req, mem_we, mem_addr} !== {3'd0, 1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL alu_fetch st=%0d req=%b we=%b addr=%h", state_o, mem_req, mem_we, mem_addr);
    end
    step();
    mem_ack = 1'b0;
    #1;
    checks++;
    if ({state_o, pc_we, reg_we, mem_req, instr} !==
        {3'd1, 1'b1, 1'b1, 1'b0, 32'h13}) begin
      errors++;
      $display("FAIL alu_exec st=%0d pcwe=%b regwe=%b req=%b ir=%h",
               state_o, pc_we, reg_we, mem_req, instr);
    end
    step();
    pc = 32'h4;
    #1;
    checks++;
    if ({state_o, mem_req, mem_addr, pc_we, reg_we} !==
        {3'd0, 1'b1, 32'h4, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL alu_next_fetch st=%0d req=%b addr=%h want 0/1/4", state_o, mem_req, mem_addr);
    end
  endtask

  task automatic test_load_wait;
    int cyc;
    do_reset();
    cyc = 0;
    pc = 32'h8;
    is_load = 1'b1;
    is_store = 1'b0;
    reg_wr_dec = 1'b1;
    alu_out = 32'h100;
    mem_ack = 1'b1;
    mem_rdata = 32'h0000_2003;
    step();
    cyc++;
    mem_ack = 1'b0;
    #1;
    checks++;
    if ({state_o, pc_we, reg_we, mem_req} !== {3'd1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL load_exec st=%0d pcwe=%b regwe=%b req=%b", state_o, pc_we, reg_we, mem_req);
    end
    step();
    cyc++;
    for (int i = 0; i < 3; i++) begin
      mem_ack = (i == 2);
      mem_rdata = 32'hDEAD_BEEF;
      #1;
      checks++;
      if ({state_o, mem_req, mem_we, mem_addr} !== {3'd2, 1'b1, 1'b0, 32'h100}) begin
        errors++;
        $display("FAIL load_mem%0d st=%0d req=%b we=%b addr=%h", i, state_o, mem_req, mem_we, mem_addr);
      end
      step();
      cyc++;
    end
    mem_ack = 1'b0;
    #1;
    checks++;
    if ({state_o, pc_we, reg_we, read_data} !== {3'd3, 1'b1, 1'b1, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL load_wb st=%0d pcwe=%b regwe=%b rd=%h", state_o, pc_we, reg_we, read_data);
    end
    step();
    cyc++;
    #1;
    checks++;
    if ({cyc, state_o} !== {32'd6, 3'd0}) begin
      errors++;
      $display("FAIL load_latency cycles=%0d st=%0d want 6/0", cyc, state_o);
    end
  endtask

  task automatic test_store;
    do_reset();
    pc = 32'h20;
    is_load = 1'b0;
    is_store = 1'b1;
    reg_wr_dec = 1'b1;
    alu_out = 32'h40;
    store_data = 32'h1234_5678;
    mem_ack = 1'b1;
    mem_rdata = 32'h0000_0023;
    step();
    mem_ack = 1'b0;
    step();
    mem_ack = 1'b1;
    #1;
    checks++;
    if ({state_o, mem_req, mem_we, mem_addr, mem_wdata} !==
        {3'd2, 1'b1, 1'b1, 32'h40, 32'h1234_5678}) begin
      errors++;
      $display("FAIL store_mem st=%0d req=%b we=%b addr=%h wd=%h",
               state_o, mem_req, mem_we, mem_addr, mem_wdata);
    end
    step();
    mem_ack = 1'b0;
    #1;
    checks++;
    if ({state_o, pc_we, reg_we, read_data} !== {3'd3, 1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL store_wb st=%0d pcwe=%b regwe=%b rd=%h", state_o, pc_we, reg_we, read_data);
    end
    step();
  endtask

  task automatic test_reset_mid;
    logic [135:0] z;
    do_reset();
    pc = 32'h30;
    is_load = 1'b1;
    is_store = 1'b0;
    alu_out = 32'h80;
    mem_ack = 1'b1;
    mem_rdata = 32'h11;
    step();
    mem_ack = 1'b0;
    step();
    #1;
    checks++;
    if (state_o !== 3'd2) begin
      errors++;
      $display("FAIL rstmid_in_mem st=%0d want 2", state_o);
    end
    step();
    reset = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    #1;
    z = {mem_req, mem_we, pc_we, reg_we, bus_err, state_o,
         mem_addr, mem_wdata, instr, read_data};
    checks++;
    if (z !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got %h want 0", z);
    end
    step();
    reset = 1'b0;
    mem_ack = 1'b0;
    #1;
    checks++;
    if ({state_o, mem_req, mem_addr, instr, read_data} !==
        {3'd0, 1'b1, 32'h30, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL rstmid_after st=%0d req=%b addr=%h ir=%h rd=%h",
               state_o, mem_req, mem_addr, instr, read_data);
    end
  endtask

  task automatic test_spurious;
    do_reset();
    pc = 32'h50;
    is_load = 1'b0;
    is_store = 1'b0;
    reg_wr_dec = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hA5;
    step();
    mem_rdata = 32'hFFFF_0000;
    #1;
    checks++;
    if ({state_o, pc_we, reg_we, instr} !== {3'd1, 1'b1, 1'b0, 32'hA5}) begin
      errors++;
      $display("FAIL spur_exec st=%0d pcwe=%b regwe=%b ir=%h", state_o, pc_we, reg_we, instr);
    end
    step();
    mem_ack = 1'b0;
    #1;
    checks++;
    if ({state_o, instr} !== {3'd0, 32'hA5}) begin
      errors++;
      $display("FAIL spur_after st=%0d ir=%h want 0/a5", state_o, instr);
    end
  endtask

  task automatic test_random;
    cyc_t c;
    logic [134:0] obs, expv;
    int k;
    int sel;
    do_reset();
    m_ir = '0;
    m_rd = '0;
    for (int n = 0; n < 40; n++) begin
      pc = $urandom & 32'hFFFF_FFFC;
      alu_out = $urandom;
      store_data = $urandom;
      sel = $urandom_range(0, 3);
      is_load = (sel == 1) || (sel == 3);
      is_store = (sel == 2) || (sel == 3);
      reg_wr_dec = 1'($urandom_range(0, 1));
      plan(pc, alu_out, store_data, $urandom, is_load, is_store, reg_wr_dec,
           $urandom_range(0, 3), $urandom_range(0, 3));
      k = 0;
      while (q.size() > 0) begin
        c = q.pop_front();
        mem_ack = c.ack;
        mem_rdata = c.rdata;
        #1;
        obs = {mem_req, mem_we, pc_we, reg_we, state_o,
               c.req ? mem_addr : 32'h0, c.we ? mem_wdata : 32'h0,
               instr, read_data};
        expv = {c.req, c.we, c.pcwe, c.regwe, c.st,
                c.addr, c.we ? c.wdata : 32'h0, c.ir, c.rd};
        checks++;
        if (obs !== expv) begin
          errors++;
          $display("FAIL rand_i%0d_c%0d got %h want %h", n, k, obs, expv);
        end
        step();
        k++;
      end
    end
    mem_ack = 1'b0;
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout;
    do_reset();
    pc = 32'h60;
    mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({state_o, bus_err, mem_req} !== {3'd0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL to_wait%0d st=%0d err=%b req=%b", i, state_o, bus_err, mem_req);
      end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      mem_ack = (i > 0);
      #1;
      checks++;
      if ({state_o, bus_err, mem_req, pc_we, reg_we} !==
          {3'd4, 1'b1, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL to_err%0d st=%0d err=%b req=%b", i, state_o, bus_err, mem_req);
      end
      step();
    end
    do_reset();
    #1;
    checks++;
    if ({state_o, bus_err} !== {3'd0, 1'b0}) begin
      errors++;
      $display("FAIL to_reset st=%0d err=%b", state_o, bus_err);
    end
    for (int i = 0; i < 5; i++) begin
      mem_ack = (i == 4);
      mem_rdata = 32'h77;
      #1;
      step();
    end
    mem_ack = 1'b0;
    #1;
    checks++;
    if ({state_o, bus_err, instr} !== {3'd1, 1'b0, 32'h77}) begin
      errors++;
      $display("FAIL to_ack_at_limit st=%0d err=%b ir=%h", state_o, bus_err, instr);
    end
  endtask
`else
  task automatic test_timeout;
    do_reset();
    pc = 32'h60;
    mem_ack = 1'b0;
    repeat (20) step();
    checks++;
    if ({state_o, bus_err, mem_req} !== {3'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL no_timeout st=%0d err=%b req=%b", state_o, bus_err, mem_req);
    end
    mem_ack = 1'b1;
    mem_rdata = 32'h77;
    step();
    mem_ack = 1'b0;
    #1;
    checks++;
    if ({state_o, bus_err, instr} !== {3'd1, 1'b0, 32'h77}) begin
      errors++;
      $display("FAIL no_timeout_ack st=%0d err=%b ir=%h", state_o, bus_err, instr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_store();
    test_reset_mid();
    test_spurious();
    test_random();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
